// File: rtl/led_toggle_scheduler.sv
// led_toggle_scheduler
//   Turns 12 raw board buttons into per-color enables for four RGB LEDs.
//   Each button is synchronized and debounced, and every clean press toggles
//   one enable. A round-robin scheduler then lights at most one LED at a time,
//   skipping LEDs that have no color enabled.
//
// Ports
//   clk                       system clock, rising edge
//   rst_n                     asynchronous active-low reset
//   b1..b12                   raw active-high buttons (b3k+1/2/3 -> LED k+1 r/g/b)
//   mux_en                    1 = one LED at a time, 0 = all enabled colors lit
//   led_1_r .. led_4_b        registered LED drives, active-high
//   active_led                index of the LED currently scheduled
//   active_valid              scheduler is scanning
//
// Scheduler states
//   state | meaning
//   IDLE  | no color enabled anywhere, nothing scheduled
//   SCAN  | cur owns the current slot, slot counts cycles within it

module led_toggle_scheduler #(
  parameter int DEB_CYCLES  = 4,
  parameter int SLOT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       b1,
  input  logic       b2,
  input  logic       b3,
  input  logic       b4,
  input  logic       b5,
  input  logic       b6,
  input  logic       b7,
  input  logic       b8,
  input  logic       b9,
  input  logic       b10,
  input  logic       b11,
  input  logic       b12,
  input  logic       mux_en,
  output logic       led_1_r,
  output logic       led_1_g,
  output logic       led_1_b,
  output logic       led_2_r,
  output logic       led_2_g,
  output logic       led_2_b,
  output logic       led_3_r,
  output logic       led_3_g,
  output logic       led_3_b,
  output logic       led_4_r,
  output logic       led_4_g,
  output logic       led_4_b,
  output logic [1:0] active_led,
  output logic       active_valid
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  logic [11:0]   btn_raw;
  logic [11:0]   sync_1;
  logic [11:0]   sync_2;
  logic [11:0]   stable;
  logic [CW-1:0] count [12];
  logic [11:0]   accept;
  logic [11:0]   press;
  logic [11:0]   en;
  logic [3:0]    led_any;

  state_t        state, state_nxt;
  logic [1:0]    cur, cur_nxt;
  logic [SW-1:0] slot, slot_nxt;
  logic [11:0]   led_q;

  assign btn_raw = {b12, b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1};

  // A level is accepted on the cycle its mismatch count reaches the limit;
  // only accepted rising levels toggle an enable.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 12; i++) begin
      accept[i] = (sync_2[i] != stable[i]) && (count[i] == DEB_LAST);
    end
    press = accept & sync_2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
      stable <= '0;
      en     <= '0;
      for (int i = 0; i < 12; i++) begin
        count[i] <= '0;
      end
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      en     <= en ^ press;
      for (int i = 0; i < 12; i++) begin
        if (sync_2[i] == stable[i]) begin
          count[i] <= '0;
        end else if (accept[i]) begin
          count[i]  <= '0;
          stable[i] <= sync_2[i];
        end else begin
          count[i] <= count[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      led_any[k] = |en[3*k +: 3];
    end
  end

  // First LED with any color after 'from', wrapping; returns 'from' itself
  // when it is the only candidate. Descending scan so the nearest wins.
  function automatic logic [1:0] next_led(input logic [1:0] from, input logic [3:0] any);
    logic [1:0] idx;
    next_led = from;
    for (int off = 4; off >= 1; off--) begin
      idx = from + 2'(off);
      if (any[idx]) next_led = idx;
    end
  endfunction

  function automatic logic [1:0] lowest_led(input logic [3:0] any);
    lowest_led = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (any[k]) lowest_led = 2'(k);
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur   <= '0;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      slot  <= slot_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    slot_nxt  = slot;
    case (state)
      IDLE: begin
        if (|led_any) begin
          state_nxt = SCAN;
          cur_nxt   = lowest_led(led_any);
          slot_nxt  = '0;
        end
      end
      SCAN: begin
        if (!(|led_any)) begin
          state_nxt = IDLE;
          slot_nxt  = '0;
        end else if (!led_any[cur] || slot == SLOT_LAST) begin
          // a dead LED gives up the rest of its slot immediately
          cur_nxt  = next_led(cur, led_any);
          slot_nxt = '0;
        end else begin
          slot_nxt = slot + SW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q        <= '0;
      active_led   <= '0;
      active_valid <= 1'b0;
    end else begin
      for (int i = 0; i < 12; i++) begin
        led_q[i] <= en[i] & (mux_en ? (state == SCAN && cur == 2'(i / 3)) : 1'b1);
      end
      active_led   <= cur;
      active_valid <= (state == SCAN);
    end
  end

  assign {led_4_b, led_4_g, led_4_r,
          led_3_b, led_3_g, led_3_r,
          led_2_b, led_2_g, led_2_r,
          led_1_b, led_1_g, led_1_r} = led_q;

endmodule

// File: tb/tb_led_toggle_scheduler.sv
module tb_led_toggle_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] btn;
  logic        mux_en;
  logic        led_1_r, led_1_g, led_1_b, led_2_r, led_2_g, led_2_b;
  logic        led_3_r, led_3_g, led_3_b, led_4_r, led_4_g, led_4_b;
  logic [1:0]  active_led;
  logic        active_valid;
  logic [11:0] leds;

  int n_vec = 0;
  int n_err = 0;

  led_toggle_scheduler #(.DEB_CYCLES(4), .SLOT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .b1(btn[0]), .b2(btn[1]), .b3(btn[2]), .b4(btn[3]),
    .b5(btn[4]), .b6(btn[5]), .b7(btn[6]), .b8(btn[7]),
    .b9(btn[8]), .b10(btn[9]), .b11(btn[10]), .b12(btn[11]),
    .mux_en(mux_en),
    .led_1_r(led_1_r), .led_1_g(led_1_g), .led_1_b(led_1_b),
    .led_2_r(led_2_r), .led_2_g(led_2_g), .led_2_b(led_2_b),
    .led_3_r(led_3_r), .led_3_g(led_3_g), .led_3_b(led_3_b),
    .led_4_r(led_4_r), .led_4_g(led_4_g), .led_4_b(led_4_b),
    .active_led(active_led), .active_valid(active_valid)
  );

  always #5 clk = ~clk;

  // bit i of leds belongs to button i+1
  assign leds = {led_4_b, led_4_g, led_4_r, led_3_b, led_3_g, led_3_r,
                 led_2_b, led_2_g, led_2_r, led_1_b, led_1_g, led_1_r};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    btn    = '0;
    mux_en = 1'b0;

    // reset held with every button pressed
    btn = '1;
    repeat (5) step();
    chk("rst_leds", leds, 12'h000);
    chk("rst_valid", 12'(active_valid), 12'd0);
    chk("rst_active", 12'(active_led), 12'd0);
    rst_n = 1'b1;
    repeat (6) step();
    chk("allhigh_e6", leds, 12'h000);
    step();
    chk("allhigh_e7", leds, 12'hFFF);
    step();
    chk("allhigh_valid_e8", 12'(active_valid), 12'd1);
    chk("allhigh_active_e8", 12'(active_led), 12'd0);
    btn = '0;
    repeat (10) step();
    chk("release_noop", leds, 12'hFFF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_leds", leds, 12'h000);
    chk("async_rst_valid", 12'(active_valid), 12'd0);
    step();
    rst_n = 1'b1;
    step();

    // unscheduled: short pulse ignored, long hold toggles, second press clears
    btn[0] = 1'b1;
    repeat (3) step();
    btn[0] = 1'b0;
    repeat (10) step();
    chk("short_pulse", leds, 12'h000);
    btn[0] = 1'b1;
    repeat (6) step();
    chk("hold_e6", leds, 12'h000);
    step();
    chk("hold_e7", leds, 12'h001);
    repeat (3) step();
    btn[0] = 1'b0;
    repeat (10) step();
    chk("release_keeps", leds, 12'h001);
    btn[0] = 1'b1;
    repeat (7) step();
    chk("second_press", leds, 12'h000);
    repeat (3) step();
    btn[0] = 1'b0;
    repeat (10) step();

    // scheduled: LED1 green and LED4 red alternate every 8 cycles
    mux_en  = 1'b1;
    btn[1]  = 1'b1;
    btn[9]  = 1'b1;
    repeat (7) step();
    chk("sched_e7_leds", leds, 12'h000);
    chk("sched_e7_valid", 12'(active_valid), 12'd0);
    for (int e = 8; e < 40; e++) begin
      step();
      if (e == 10) btn = '0;
      chk("alt_leds", leds, (((e - 8) / 8) % 2 == 0) ? 12'h002 : 12'h200);
      chk("alt_active", 12'(active_led), (((e - 8) / 8) % 2 == 0) ? 12'd0 : 12'd3);
      chk("alt_valid", 12'(active_valid), 12'd1);
    end
    btn[1] = 1'b1;
    btn[9] = 1'b1;
    repeat (8) step();
    chk("alt_off_leds", leds, 12'h000);
    chk("alt_off_valid", 12'(active_valid), 12'd0);
    repeat (2) step();
    btn = '0;
    repeat (8) step();

    // single LED: held across slot boundaries
    btn[8] = 1'b1;
    repeat (7) step();
    chk("solo_e7", leds, 12'h000);
    for (int e = 8; e <= 30; e++) begin
      step();
      if (e == 10) btn = '0;
      chk("solo_leds", leds, 12'h100);
      chk("solo_active", 12'(active_led), 12'd2);
    end
    btn[8] = 1'b1;
    repeat (8) step();
    chk("solo_off_leds", leds, 12'h000);
    chk("solo_off_valid", 12'(active_valid), 12'd0);
    repeat (2) step();
    btn = '0;
    repeat (8) step();

    // preempt: LED2 green turned off while it owns the slot
    btn[4]  = 1'b1;
    btn[11] = 1'b1;
    for (int e = 1; e <= 36; e++) begin
      step();
      if (e == 10) btn = '0;
    end
    chk("pre_preempt", leds, 12'h800);
    btn[4] = 1'b1;
    repeat (6) step();
    chk("preempt_e42_leds", leds, 12'h010);
    chk("preempt_e42_active", 12'(active_led), 12'd1);
    step();
    chk("preempt_e43_leds", leds, 12'h000);
    step();
    chk("preempt_e44_leds", leds, 12'h800);
    chk("preempt_e44_active", 12'(active_led), 12'd3);
    repeat (2) step();
    btn[4] = 1'b0;
    repeat (8) step();

    // reset mid-slot with three LEDs enabled
    mux_en = 1'b0;
    btn[0] = 1'b1;
    btn[6] = 1'b1;
    repeat (10) step();
    btn = '0;
    repeat (10) step();
    chk("three_en", leds, 12'h841);
    mux_en = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_leds", leds, 12'h000);
    chk("mid_rst_valid", 12'(active_valid), 12'd0);
    chk("mid_rst_active", 12'(active_led), 12'd0);
    repeat (2) step();
    rst_n = 1'b1;
    mux_en = 1'b0;
    repeat (20) step();
    chk("post_rst_leds", leds, 12'h000);
    chk("post_rst_valid", 12'(active_valid), 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
